// File: rtl/reg_file_mp_pkg.sv
// Shared types and helpers for the multi-port register file and its clear engine.
package reg_file_pkg;

   // Bulk-clear sequencer states.
   typedef enum logic [1:0] {
      CLR_IDLE = 2'd0,
      CLR_RUN  = 2'd1,
      CLR_DONE = 2'd2
   } clr_state_t;

   // Widest entry byte_merge can handle; callers cast their own width in and out.
   localparam int MAX_DATA_W = 256;
   localparam int MAX_BE_W   = MAX_DATA_W / 8;

   // Replace the bytes of old_d selected by be with the matching bytes of new_d.
   // Used by both the storage write path and the read bypass so they can never disagree.
   function automatic logic [MAX_DATA_W-1:0] byte_merge(
      input logic [MAX_DATA_W-1:0] old_d,
      input logic [MAX_DATA_W-1:0] new_d,
      input logic [MAX_BE_W-1:0]   be
   );
      logic [MAX_DATA_W-1:0] res;
      res = old_d;
      for (int i = 0; i < MAX_BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_d[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle of the register file: one write port, NUM_RD read ports, bulk-clear control.
//
// Write handshake: a write takes effect on the rising edge where w_en and w_ready are both 1.
// w_ready is low only while the clear engine is walking the array; a w_en seen with
// w_ready low is dropped, the master must re-present it if it still wants it.
interface reg_file_mp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_RD     = 2
);
   localparam int BE_W = DATA_WIDTH / 8;

   logic                         w_en;
   logic [ADDR_WIDTH-1:0]        w_addr;
   logic [DATA_WIDTH-1:0]        w_data;
   logic [BE_W-1:0]              w_be;
   logic                         w_ready;
   logic [NUM_RD*ADDR_WIDTH-1:0] r_addr;
   logic [NUM_RD*DATA_WIDTH-1:0] r_data;
   logic [NUM_RD-1:0]            r_valid;
   logic                         clr_req;
   logic                         clr_busy;
   logic                         clr_done;

   modport master (
      output w_en, w_addr, w_data, w_be, r_addr, clr_req,
      input  w_ready, r_data, r_valid, clr_busy, clr_done
   );

   modport slave (
      input  w_en, w_addr, w_data, w_be, r_addr, clr_req,
      output w_ready, r_data, r_valid, clr_busy, clr_done
   );

endinterface

// File: rtl/reg_file_mp_clr_fsm.sv
// Bulk-clear sequencer: walks every entry once, then emits a one-cycle done pulse.
// Also owns w_ready, since writes are blocked exactly while the walk is running.
module reg_file_clr_fsm
   import reg_file_pkg::*;
#(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clr_req_i,
   output logic                  clr_busy_o,
   output logic                  clr_done_o,
   output logic                  w_ready_o,
   output logic                  clr_en_o,
   output logic [ADDR_WIDTH-1:0] clr_addr_o,
   output clr_state_t            state_o
);

   // Highest entry index; the walk stops here instead of wrapping into a second pass.
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   clr_state_t            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // State and walk-counter registers; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= CLR_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and status outputs.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clr_busy_o = 1'b0;
      clr_done_o = 1'b0;
      w_ready_o  = 1'b1;
      clr_en_o   = 1'b0;
      case (state_q)
         CLR_IDLE: begin
            if (clr_req_i) begin
               state_d = CLR_RUN;
               cnt_d   = '0;
            end
         end
         CLR_RUN: begin
            clr_busy_o = 1'b1;
            w_ready_o  = 1'b0;
            clr_en_o   = 1'b1;
            if (cnt_q == LAST_ADDR) state_d = CLR_DONE;
            else                    cnt_d   = cnt_q + 1'b1;
         end
         CLR_DONE: begin
            clr_done_o = 1'b1;
            cnt_d      = '0;
            state_d    = CLR_IDLE;
         end
         default: begin
            state_d = CLR_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign clr_addr_o = cnt_q;
   assign state_o    = state_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: NUM_RD combinational read ports, one byte-enabled
// write port, per-entry valid bits, optional write-to-read bypass and a bulk-clear engine.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   reg_file_mp_if.slave  bus,
   output clr_state_t    dbg_clr_state_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   // Data is deliberately not reset; the valid bits mask stale contents.
   logic [DATA_WIDTH-1:0]        mem_q [DEPTH];
   logic [DEPTH-1:0]             valid_q, valid_d;

   logic                         w_ready;
   logic                         clr_busy;
   logic                         clr_done;
   logic                         clr_en;
   logic [ADDR_WIDTH-1:0]        clr_addr;
   logic                         wr_acc;
   logic [DATA_WIDTH-1:0]        wr_merged;

   logic [DATA_WIDTH-1:0]        rd_data [NUM_RD];
   logic                         rd_valid [NUM_RD];
   logic [NUM_RD*DATA_WIDTH-1:0] r_data_flat;
   logic [NUM_RD-1:0]            r_valid_flat;

   reg_file_clr_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clr_fsm (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr_req_i  (bus.clr_req),
      .clr_busy_o (clr_busy),
      .clr_done_o (clr_done),
      .w_ready_o  (w_ready),
      .clr_en_o   (clr_en),
      .clr_addr_o (clr_addr),
      .state_o    (dbg_clr_state_o)
   );

   assign wr_acc    = bus.w_en & w_ready;
   assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_W'(mem_q[bus.w_addr]),
                                             MAX_DATA_W'(bus.w_data),
                                             MAX_BE_W'(bus.w_be)));

   // Storage update: the clear walk and accepted writes never coincide (w_ready is low).
   always_ff @(posedge clk) begin
      if (clr_en)      mem_q[clr_addr]   <= '0;
      else if (wr_acc) mem_q[bus.w_addr] <= wr_merged;
   end

   // Next valid vector: a write marks its entry even with no byte enabled.
   always_comb begin
      valid_d = valid_q;
      if (clr_en)      valid_d[clr_addr]   = 1'b0;
      else if (wr_acc) valid_d[bus.w_addr] = 1'b1;
   end

   // Valid bits are the only array state that reset touches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) valid_q <= '0;
      else          valid_q <= valid_d;
   end

   // Independent read ports; during a clear every port reads as empty.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic                  hit;
      assign ra          = bus.r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign hit         = (BYPASS != 0) && wr_acc && (ra == bus.w_addr);
      assign rd_data[k]  = clr_busy ? '0   : (hit ? wr_merged : mem_q[ra]);
      assign rd_valid[k] = clr_busy ? 1'b0 : (hit ? 1'b1      : valid_q[ra]);
   end

   // Pack the per-port results onto the flat bus vectors.
   always_comb begin
      r_data_flat  = '0;
      r_valid_flat = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         r_data_flat[k*DATA_WIDTH +: DATA_WIDTH] = rd_data[k];
         r_valid_flat[k]                         = rd_valid[k];
      end
   end

   assign bus.r_data   = r_data_flat;
   assign bus.r_valid  = r_valid_flat;
   assign bus.w_ready  = w_ready;
   assign bus.clr_busy = clr_busy;
   assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three instances (32b/16 entries without and with bypass, driven
// identically, and a 16b/8 entries/4-port bypass instance for random traffic), all checked
// every cycle against an array-and-cycle-count model of the register file.
module tb_reg_file_mp;
   import reg_file_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   // Stimulus: index 0 drives instances a and b, index 1 drives instance c.
   logic        in_w_en   [2];
   logic [3:0]  in_w_addr [2];
   logic [31:0] in_w_data [2];
   logic [3:0]  in_w_be   [2];
   logic        in_clr    [2];
   logic [7:0]  ra_ab;
   logic [11:0] ra_c;

   clr_state_t dbg_a, dbg_b, dbg_c;

   reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(2)) if_a ();
   reg_file_mp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(2)) if_b ();
   reg_file_mp_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4)) if_c ();

   assign if_a.w_en = in_w_en[0];    assign if_b.w_en = in_w_en[0];
   assign if_a.w_addr = in_w_addr[0]; assign if_b.w_addr = in_w_addr[0];
   assign if_a.w_data = in_w_data[0]; assign if_b.w_data = in_w_data[0];
   assign if_a.w_be = in_w_be[0];    assign if_b.w_be = in_w_be[0];
   assign if_a.clr_req = in_clr[0];  assign if_b.clr_req = in_clr[0];
   assign if_a.r_addr = ra_ab;       assign if_b.r_addr = ra_ab;
   assign if_c.w_en = in_w_en[1];
   assign if_c.w_addr = in_w_addr[1][2:0];
   assign if_c.w_data = in_w_data[1][15:0];
   assign if_c.w_be = in_w_be[1][1:0];
   assign if_c.clr_req = in_clr[1];
   assign if_c.r_addr = ra_c;

   reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(2), .BYPASS(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .bus(if_a), .dbg_clr_state_o(dbg_a));
   reg_file_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_RD(2), .BYPASS(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .bus(if_b), .dbg_clr_state_o(dbg_b));
   reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4), .BYPASS(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .bus(if_c), .dbg_clr_state_o(dbg_c));

   // Reference model: contents, known-byte masks, valid bits, and the cycle the last clear began.
   logic [31:0] mdl_mem [2][16];
   logic [3:0]  mdl_km  [2][16];
   logic        mdl_v   [2][16];
   int          clr_begin [2];
   int          depth_of  [2] = '{16, 8};
   int          nb_of     [2] = '{4, 2};
   int          cyc;

   int n_vec;
   int n_err;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // A clear occupies DEPTH cycles from clr_begin, then one done cycle.
   function automatic bit exp_busy(input int m);
      int p = cyc - clr_begin[m];
      return (p >= 0) && (p < depth_of[m]);
   endfunction

   function automatic bit exp_done(input int m);
      return (cyc - clr_begin[m]) == depth_of[m];
   endfunction

   function automatic logic [1:0] exp_state(input int m);
      if (exp_busy(m)) return CLR_RUN;
      if (exp_done(m)) return CLR_DONE;
      return CLR_IDLE;
   endfunction

   function automatic logic [31:0] be_mask(input logic [3:0] be);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   // Expected read of address a this cycle; msk selects the bits whose value is defined.
   task automatic exp_read(input int m, input bit byp, input int a,
                           output logic [31:0] d, output logic [31:0] msk, output logic v);
      if (exp_busy(m)) begin
         d = '0; msk = (nb_of[m] == 4) ? 32'hFFFF_FFFF : 32'h0000_FFFF; v = 1'b0;
      end else begin
         d = mdl_mem[m][a]; msk = be_mask(mdl_km[m][a]); v = mdl_v[m][a];
         if (byp && in_w_en[m] && (int'(in_w_addr[m]) == a)) begin
            for (int i = 0; i < nb_of[m]; i++) begin
               if (in_w_be[m][i]) begin
                  d[8*i +: 8]   = in_w_data[m][8*i +: 8];
                  msk[8*i +: 8] = 8'hFF;
               end
            end
            v = 1'b1;
         end
         if (!v) msk = '0;
      end
   endtask

   // What one rising edge does to the model, given the inputs held during the cycle.
   task automatic model_edge(input int m);
      int p = cyc - clr_begin[m];
      int a;
      if (p >= 0 && p < depth_of[m]) begin
         mdl_mem[m][p] = '0;
         mdl_km[m][p]  = (nb_of[m] == 4) ? 4'hF : 4'h3;
         mdl_v[m][p]   = 1'b0;
      end else begin
         if (in_w_en[m]) begin
            a = int'(in_w_addr[m]);
            for (int i = 0; i < nb_of[m]; i++) begin
               if (in_w_be[m][i]) begin
                  mdl_mem[m][a][8*i +: 8] = in_w_data[m][8*i +: 8];
                  mdl_km[m][a][i] = 1'b1;
               end
            end
            mdl_v[m][a] = 1'b1;
         end
         if (p != depth_of[m] && in_clr[m]) clr_begin[m] = cyc + 1;
      end
   endtask

   task automatic check_all();
      logic [31:0] d, msk;
      logic v;
      int a;
      check_val("a_busy", if_a.clr_busy, exp_busy(0));
      check_val("a_done", if_a.clr_done, exp_done(0));
      check_val("a_wready", if_a.w_ready, !exp_busy(0));
      check_val("a_state", dbg_a, exp_state(0));
      check_val("b_busy", if_b.clr_busy, exp_busy(0));
      check_val("b_done", if_b.clr_done, exp_done(0));
      check_val("c_busy", if_c.clr_busy, exp_busy(1));
      check_val("c_done", if_c.clr_done, exp_done(1));
      check_val("c_wready", if_c.w_ready, !exp_busy(1));
      check_val("c_state", dbg_c, exp_state(1));
      for (int k = 0; k < 2; k++) begin
         a = int'(ra_ab[k*4 +: 4]);
         exp_read(0, 1'b0, a, d, msk, v);
         check_val($sformatf("a_rvalid%0d", k), if_a.r_valid[k], v);
         check_val($sformatf("a_rdata%0d", k), if_a.r_data[k*32 +: 32] & msk, d & msk);
         exp_read(0, 1'b1, a, d, msk, v);
         check_val($sformatf("b_rvalid%0d", k), if_b.r_valid[k], v);
         check_val($sformatf("b_rdata%0d", k), if_b.r_data[k*32 +: 32] & msk, d & msk);
      end
      for (int k = 0; k < 4; k++) begin
         a = int'(ra_c[k*3 +: 3]);
         exp_read(1, 1'b1, a, d, msk, v);
         check_val($sformatf("c_rvalid%0d", k), if_c.r_valid[k], v);
         check_val($sformatf("c_rdata%0d", k), if_c.r_data[k*16 +: 16] & msk[15:0], d[15:0] & msk[15:0]);
      end
   endtask

   // Inputs change at posedge+1; outputs are sampled at posedge+4; the model steps at the edge.
   task automatic settle();
      #3;
      check_all();
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      cyc++;
      #1;
   endtask

   task automatic tick();
      settle();
      edge_step();
   endtask

   task automatic drive_write(input int m, input int addr, input logic [31:0] data, input logic [3:0] be);
      in_w_en[m] = 1'b1; in_w_addr[m] = 4'(addr); in_w_data[m] = data; in_w_be[m] = be;
   endtask

   task automatic idle_inputs();
      for (int m = 0; m < 2; m++) begin
         in_w_en[m] = 1'b0; in_w_addr[m] = '0; in_w_data[m] = '0; in_w_be[m] = '0; in_clr[m] = 1'b0;
      end
   endtask

   task automatic apply_reset();
      idle_inputs();
      reset_n = 1'b0;
      for (int m = 0; m < 2; m++) begin
         clr_begin[m] = -1000000;
         for (int a = 0; a < 16; a++) mdl_v[m][a] = 1'b0;
      end
      #1;
      check_val("rst_a_busy", if_a.clr_busy, 1'b0);
      check_val("rst_c_busy", if_c.clr_busy, 1'b0);
      check_val("rst_a_state", dbg_a, CLR_IDLE);
      check_val("rst_a_rvalid", if_a.r_valid, 2'b00);
      check_val("rst_b_rvalid", if_b.r_valid, 2'b00);
      check_val("rst_c_rvalid", if_c.r_valid, 4'b0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   logic [31:0] fill_d [16];
   int busy_cnt, done_cnt;

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      ra_ab = '0; ra_c = '0;
      for (int m = 0; m < 2; m++)
         for (int a = 0; a < 16; a++) begin
            mdl_mem[m][a] = '0; mdl_km[m][a] = '0; mdl_v[m][a] = 1'b0;
         end
      #2;
      apply_reset();

      // Fresh after reset: nothing valid anywhere; then a full write reads back on both ports.
      for (int a = 0; a < 16; a++) begin
         ra_ab = {4'(15 - a), 4'(a)};
         settle();
         check_val("t1_empty", if_a.r_valid, 2'b00);
         edge_step();
      end
      drive_write(0, 3, 32'hDEAD_BEEF, 4'hF);
      tick();
      in_w_en[0] = 1'b0; ra_ab = {4'd3, 4'd3};
      settle();
      check_val("t1_rd0", if_a.r_data[31:0], 32'hDEAD_BEEF);
      check_val("t1_rd1", if_a.r_data[63:32], 32'hDEAD_BEEF);
      check_val("t1_rv", if_a.r_valid, 2'b11);
      edge_step();

      // Partial byte write, and a write with no bytes enabled still marks the entry valid.
      drive_write(0, 3, 32'h0000_1234, 4'b0011);
      tick();
      in_w_en[0] = 1'b0;
      settle();
      check_val("t2_partial", if_a.r_data[31:0], 32'hDEAD_1234);
      edge_step();
      drive_write(0, 5, 32'hFFFF_FFFF, 4'b0000);
      tick();
      in_w_en[0] = 1'b0; ra_ab = {4'd5, 4'd5};
      settle();
      check_val("t2_be0_valid", if_a.r_valid, 2'b11);
      edge_step();

      // Same-cycle read of the written address: old contents without bypass, merged with it.
      drive_write(0, 7, 32'hA5A5_A5A5, 4'hF);
      ra_ab = {4'd3, 4'd7};
      settle();
      check_val("t3_nobyp_valid", if_a.r_valid[0], 1'b0);
      check_val("t3_byp_data", if_b.r_data[31:0], 32'hA5A5_A5A5);
      check_val("t3_byp_valid", if_b.r_valid[0], 1'b1);
      edge_step();
      drive_write(0, 3, 32'h1122_3344, 4'b0100);
      ra_ab = {4'd3, 4'd3};
      settle();
      check_val("t3_nobyp_old", if_a.r_data[31:0], 32'hDEAD_1234);
      check_val("t3_byp_merge", if_b.r_data[31:0], 32'hDE22_1234);
      edge_step();
      in_w_en[0] = 1'b0;
      settle();
      check_val("t3_after", if_a.r_data[31:0], 32'hDE22_1234);
      edge_step();

      // Fill, then clear: writes offered during the walk must be dropped.
      for (int a = 0; a < 16; a++) begin
         drive_write(0, a, $urandom, 4'hF);
         tick();
      end
      in_w_en[0] = 1'b0; in_clr[0] = 1'b1;
      tick();
      in_clr[0] = 1'b0;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         in_w_en[0] = (i < 16); in_w_addr[0] = 4'($urandom_range(0, 15));
         in_w_data[0] = $urandom; in_w_be[0] = 4'hF; ra_ab = 8'($urandom_range(0, 255));
         settle();
         busy_cnt += int'(if_a.clr_busy);
         done_cnt += int'(if_a.clr_done);
         if (i < 16)  check_val("t4_rd_clr", if_a.r_data, 64'd0);
         if (i == 16) check_val("t4_done", if_a.clr_done, 1'b1);
         edge_step();
      end
      check_val("t4_busy_cycles", busy_cnt, 16);
      check_val("t4_done_cycles", done_cnt, 1);
      in_w_en[0] = 1'b0;
      for (int a = 0; a < 16; a++) begin
         ra_ab = {4'(a), 4'(a)};
         settle();
         check_val("t4_cleared_valid", if_a.r_valid, 2'b00);
         edge_step();
      end
      for (int a = 0; a < 16; a++) begin
         drive_write(0, a, 32'hFFFF_FFFF, 4'b0000);
         tick();
      end
      in_w_en[0] = 1'b0;
      for (int a = 0; a < 16; a++) begin
         ra_ab = {4'(a), 4'(a)};
         settle();
         check_val("t4_cleared_data", if_a.r_data[31:0], 32'd0);
         edge_step();
      end

      // Reset during the clear walk: entries from the interrupted index onward keep their data.
      for (int a = 0; a < 16; a++) begin
         fill_d[a] = $urandom;
         drive_write(0, a, fill_d[a], 4'hF);
         tick();
      end
      in_w_en[0] = 1'b0; in_clr[0] = 1'b1;
      tick();
      in_clr[0] = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      settle();
      check_val("t5_busy_pre", if_a.clr_busy, 1'b1);
      apply_reset();
      for (int a = 0; a < 16; a++) begin
         drive_write(0, a, 32'h0, 4'b0000);
         tick();
      end
      in_w_en[0] = 1'b0;
      for (int a = 0; a < 16; a++) begin
         ra_ab = {4'(a), 4'(a)};
         settle();
         check_val("t5_kept", if_a.r_data[31:0], (a < 5) ? 32'd0 : fill_d[a]);
         edge_step();
      end

      // Random traffic on every instance, including occasional clears and write+clear collisions.
      for (int i = 0; i < 1000; i++) begin
         in_w_en[0]   = ($urandom_range(0, 3) != 0);
         in_w_addr[0] = 4'($urandom_range(0, 15));
         in_w_data[0] = $urandom;
         in_w_be[0]   = 4'($urandom_range(0, 15));
         in_clr[0]    = ($urandom_range(0, 59) == 0);
         ra_ab        = 8'($urandom_range(0, 255));
         in_w_en[1]   = ($urandom_range(0, 3) != 0);
         in_w_addr[1] = 4'($urandom_range(0, 7));
         in_w_data[1] = 32'($urandom_range(0, 65535));
         in_w_be[1]   = 4'($urandom_range(0, 3));
         in_clr[1]    = ($urandom_range(0, 59) == 0);
         ra_c         = 12'($urandom_range(0, 4095));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
